ctrl_sequencer: RTL

- Multi-cycle fetch/decode/control unit for the 8-bit processor.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake and decodes them.
- Drives the ALU opcode, the register-file read/write addresses and the single-cycle write strobe.
- Sits on the initiator side of the register-file write port and the ALU opcode input.

---
 rtl/ctrl_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/control sequencer for the 8-bit core.
// Fetches 16-bit words over req/ack, decodes them and drives ALU/regfile controls.
module ctrl_sequencer #(
  parameter int unsigned          IMEM_AW  = 8,
  parameter logic [IMEM_AW-1:0]   RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [15:0]        imem_data,
  output logic [3:0]         alu_opcode,
  output logic [3:0]         read_reg1,
  output logic [3:0]         read_reg2,
  output logic [3:0]         write_reg,
  output logic               reg_write,
  output logic               imm_sel,
  output logic [7:0]         imm,
  output logic [IMEM_AW-1:0] pc,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'b0101;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t      state;
  logic [15:0] ir;
  logic [3:0]  op;
  logic        wb_strobe;

  assign op        = ir[15:12];
  assign imem_addr = pc;
  // Gating with rst drops a pending write when reset lands on the WB cycle.
  assign reg_write = wb_strobe & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      imem_req   <= 1'b1;
      ir         <= '0;
      alu_opcode <= '1;
      read_reg1  <= '0;
      read_reg2  <= '0;
      write_reg  <= '0;
      imm        <= '0;
      imm_sel    <= 1'b0;
      wb_strobe  <= 1'b0;
      halted     <= 1'b0;
    end else begin
      wb_strobe <= 1'b0;
      case (state)
        S_FETCH: begin
          imem_req <= 1'b1;
          if (imem_ack) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          alu_opcode <= (op <= 4'd4) ? op : 4'b1111;
          read_reg1  <= ir[7:4];
          read_reg2  <= ir[3:0];
          write_reg  <= ir[11:8];
          imm        <= ir[7:0];
          imm_sel    <= (op == OP_LDI);
          state      <= S_EXEC;
        end
        S_EXEC: begin
          wb_strobe <= (op <= 4'd4) || (op == OP_LDI);
          state     <= S_WB;
        end
        S_WB: begin
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            if (op == OP_JMP) pc <= IMEM_AW'(ir[7:0]);
            else              pc <= pc + IMEM_AW'(1);
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_HALT: begin
          imem_req <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          imem_req <= 1'b1;
          halted   <= 1'b0;
          state    <= S_FETCH;
        end
      endcase
    end
  end

endmodule
